// File: rtl/usq_pkg.sv
// Shared encodings for the microprogram sequencer: next-state modes and
// the instruction-register field used for dispatch.
package usq_pkg;

    typedef enum logic [2:0] {
        MODE_INC      = 3'd0,
        MODE_JUMP     = 3'd1,
        MODE_DISPATCH = 3'd2,
        MODE_COND     = 3'd3,
        MODE_WAIT     = 3'd4,
        MODE_CALL     = 3'd5,
        MODE_RET      = 3'd6,
        MODE_FETCH    = 3'd7
    } ns_mode_e;

    localparam int DISP_HI = 27;
    localparam int DISP_LO = 24;

endpackage

// File: rtl/usq_stack.sv
// Return-address LIFO for micro-subroutine calls; push/pop/clear with
// full/empty flags and a synchronous active-high reset of the pointer.
module usq_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    import usq_pkg::*;

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;

    assign w_wr_idx = IDX_W'(r_sp);
    assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
    assign o_full   = (r_sp == SP_W'(DEPTH));
    assign o_empty  = (r_sp == '0);
    assign o_data   = r_mem[w_rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_clr || i_clear) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - SP_W'(1);
        end
    end

    // NOTE: storage is left unreset; entries above the pointer are never read, so only r_sp needs clearing.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: next-address selection, state register, MOC wait
// timeout and sticky fault flags around a return-address stack.
module micro_sequencer
    import usq_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                IR_W        = 32,
    parameter int                STACK_DEPTH = 4,
    parameter int                MOC_TIMEOUT = 15,
    parameter logic [ADDR_W-1:0] FAULT_ADDR  = '1
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              moc,
    input  logic [IR_W-1:0]   ir,
    input  logic              cond,
    input  logic [2:0]        ns_mode,
    input  logic              ns_inv,
    input  logic [ADDR_W-1:0] ns_target,
    output logic [ADDR_W-1:0] state,
    output logic              waiting,
    output logic              mem_err,
    output logic              stack_err
);
    localparam int CNT_W = (MOC_TIMEOUT < 2) ? 1 : $clog2(MOC_TIMEOUT);

    ns_mode_e          w_mode;
    logic [ADDR_W-1:0] r_state;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_inc;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_wait_cnt_next;
    logic              r_mem_err;
    logic              r_stack_err;
    logic              w_set_mem_err;
    logic              w_set_stack_err;
    logic              w_push;
    logic              w_pop;
    logic              w_clear;
    logic              w_moc_ok;
    logic              w_timed_out;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;

    assign w_mode      = ns_mode_e'(ns_mode);
    assign w_inc       = r_state + ADDR_W'(1);
    assign w_moc_ok    = moc ^ ns_inv;
    assign w_timed_out = (MOC_TIMEOUT != 0) && (r_wait_cnt == CNT_W'(MOC_TIMEOUT - 1));

    assign state     = r_state;
    assign waiting   = (w_mode == MODE_WAIT) && !w_moc_ok;
    assign mem_err   = r_mem_err;
    assign stack_err = r_stack_err;

    usq_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .i_clk   (CLK),
        .i_clr   (CLR),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_clear),
        .i_data  (w_inc),
        .o_data  (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        w_next          = w_inc;
        w_wait_cnt_next = '0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        w_clear         = 1'b0;
        w_set_mem_err   = 1'b0;
        w_set_stack_err = 1'b0;
        unique case (w_mode)
            MODE_INC:      w_next = w_inc;
            MODE_JUMP:     w_next = ns_target;
            MODE_DISPATCH: w_next = ns_target + ADDR_W'(ir[DISP_HI:DISP_LO]);
            MODE_COND:     w_next = (cond ^ ns_inv) ? ns_target : w_inc;
            MODE_WAIT: begin
                if (w_moc_ok) begin
                    w_next = w_inc;
                end else if (w_timed_out) begin
                    w_next        = FAULT_ADDR;
                    w_set_mem_err = 1'b1;
                end else begin
                    w_next          = r_state;
                    w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
                end
            end
            MODE_CALL: begin
                if (w_full) begin
                    w_next          = FAULT_ADDR;
                    w_set_stack_err = 1'b1;
                end else begin
                    w_push = 1'b1;
                    w_next = ns_target;
                end
            end
            MODE_RET: begin
                if (w_empty) begin
                    w_next          = FAULT_ADDR;
                    w_set_stack_err = 1'b1;
                end else begin
                    w_pop  = 1'b1;
                    w_next = w_top;
                end
            end
            MODE_FETCH: begin
                w_next  = '0;
                w_clear = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state     <= '0;
            r_wait_cnt  <= '0;
            r_mem_err   <= 1'b0;
            r_stack_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_wait_cnt  <= w_wait_cnt_next;
            r_mem_err   <= r_mem_err | w_set_mem_err;
            r_stack_err <= r_stack_err | w_set_stack_err;
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomised and directed bench for micro_sequencer against a queue-based
// reference model of the microsequencing rules.
module tb_micro_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;
    localparam int FAULT   = 255;

    localparam logic [2:0] INC = 3'd0, JMP = 3'd1, DSP = 3'd2, CND = 3'd3,
                           WAI = 3'd4, CAL = 3'd5, RET = 3'd6, FET = 3'd7;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        moc = 1'b0;
    logic [31:0] ir = '0;
    logic        cond = 1'b0;
    logic [2:0]  ns_mode = INC;
    logic        ns_inv = 1'b0;
    logic [7:0]  ns_target = '0;
    logic [7:0]  state;
    logic        waiting;
    logic        mem_err;
    logic        stack_err;

    micro_sequencer dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .moc       (moc),
        .ir        (ir),
        .cond      (cond),
        .ns_mode   (ns_mode),
        .ns_inv    (ns_inv),
        .ns_target (ns_target),
        .state     (state),
        .waiting   (waiting),
        .mem_err   (mem_err),
        .stack_err (stack_err)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: address as an integer, the return stack as a queue.
    int m_state = 0;
    int m_stalls = 0;
    int m_stack[$];
    bit m_mem_err = 0;
    bit m_stk_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input logic [2:0] mode, input bit inv, input int tgt,
                              input bit c, input bit m, input logic [31:0] irv);
        int nxt;
        nxt = (m_state + 1) % 256;
        if (mode != WAI) m_stalls = 0;
        case (mode)
            JMP: nxt = tgt;
            DSP: nxt = (tgt + int'(irv[27:24])) % 256;
            CND: nxt = (c ^ inv) ? tgt : (m_state + 1) % 256;
            WAI: begin
                if (m ^ inv) begin
                    m_stalls = 0;
                end else if (m_stalls == TIMEOUT - 1) begin
                    nxt = FAULT;
                    m_mem_err = 1;
                    m_stalls = 0;
                end else begin
                    nxt = m_state;
                    m_stalls++;
                end
            end
            CAL: begin
                if (m_stack.size() == DEPTH) begin
                    nxt = FAULT;
                    m_stk_err = 1;
                end else begin
                    m_stack.push_back((m_state + 1) % 256);
                    nxt = tgt;
                end
            end
            RET: begin
                if (m_stack.size() == 0) begin
                    nxt = FAULT;
                    m_stk_err = 1;
                end else begin
                    nxt = m_stack.pop_back();
                end
            end
            FET: begin
                nxt = 0;
                m_stack.delete();
            end
            default: ;
        endcase
        m_state = nxt;
    endtask

    task automatic step(input logic [2:0] mode, input bit inv, input logic [7:0] tgt,
                        input bit c, input bit m, input logic [31:0] irv);
        ns_mode = mode; ns_inv = inv; ns_target = tgt; cond = c; moc = m; ir = irv;
        #1;
        check("waiting", {31'd0, waiting}, {31'd0, (mode == WAI) && !(m ^ inv)});
        @(posedge CLK);
        model_step(mode, inv, int'(tgt), c, m, irv);
        #1;
        check("state", {24'd0, state}, m_state);
        check("mem_err", {31'd0, mem_err}, {31'd0, m_mem_err});
        check("stack_err", {31'd0, stack_err}, {31'd0, m_stk_err});
    endtask

    task automatic do_clr(input logic [2:0] mode, input bit m);
        CLR = 1'b1; ns_mode = mode; moc = m;
        @(posedge CLK);
        #1;
        CLR = 1'b0;
        m_state = 0; m_stalls = 0; m_stack.delete(); m_mem_err = 0; m_stk_err = 0;
        ns_mode = INC; ns_inv = 1'b0;
        #1;
        check("clr_state", {24'd0, state}, 32'd0);
        check("clr_mem_err", {31'd0, mem_err}, 32'd0);
        check("clr_stack_err", {31'd0, stack_err}, 32'd0);
        check("clr_waiting", {31'd0, waiting}, 32'd0);
    endtask

    initial begin
        do_clr(INC, 1'b0);

        for (int i = 1; i <= 3; i++) begin
            step(INC, 0, 8'h00, 0, 0, 32'h0);
            check("inc_seq", {24'd0, state}, i);
        end
        step(JMP, 0, 8'hFF, 0, 0, 32'h0);
        step(INC, 0, 8'h00, 0, 0, 32'h0);
        check("inc_wrap", {24'd0, state}, 32'h00);

        step(DSP, 0, 8'h40, 0, 0, 32'h1AFF_FFFD);
        check("dispatch", {24'd0, state}, 32'h4A);

        step(CND, 0, 8'h20, 1, 0, 32'h0);
        check("cond_taken", {24'd0, state}, 32'h20);
        step(CND, 1, 8'h20, 1, 0, 32'h0);
        check("cond_inv", {24'd0, state}, 32'h21);

        for (int i = 0; i < 3; i++) begin
            step(WAI, 0, 8'h00, 0, 0, 32'h0);
            check("wait_hold", {24'd0, state}, 32'h21);
        end
        step(WAI, 0, 8'h00, 0, 1, 32'h0);
        check("wait_release", {24'd0, state}, 32'h22);

        for (int i = 0; i < TIMEOUT; i++) step(WAI, 0, 8'h00, 0, 0, 32'h0);
        check("timeout_addr", {24'd0, state}, 32'hFF);
        check("timeout_err", {31'd0, mem_err}, 32'd1);
        step(INC, 0, 8'h00, 0, 0, 32'h0);
        step(INC, 0, 8'h00, 0, 0, 32'h0);
        check("mem_err_sticky", {31'd0, mem_err}, 32'd1);
        do_clr(INC, 1'b0);

        step(JMP, 0, 8'h10, 0, 0, 32'h0);
        for (int i = 1; i <= DEPTH; i++) step(CAL, 0, 8'(i * 16 + 16), 0, 0, 32'h0);
        for (int i = 0; i < DEPTH; i++) step(RET, 0, 8'h00, 0, 0, 32'h0);
        check("ret_lifo_last", {24'd0, state}, 32'h11);
        for (int i = 0; i < DEPTH; i++) step(CAL, 0, 8'h80, 0, 0, 32'h0);
        step(CAL, 0, 8'h80, 0, 0, 32'h0);
        check("call_full_addr", {24'd0, state}, 32'hFF);
        check("call_full_err", {31'd0, stack_err}, 32'd1);
        do_clr(INC, 1'b0);
        step(RET, 0, 8'h00, 0, 0, 32'h0);
        check("ret_empty_addr", {24'd0, state}, 32'hFF);
        check("ret_empty_err", {31'd0, stack_err}, 32'd1);
        do_clr(INC, 1'b0);

        step(CAL, 0, 8'h30, 0, 0, 32'h0);
        step(CAL, 0, 8'h50, 0, 0, 32'h0);
        step(WAI, 0, 8'h00, 0, 0, 32'h0);
        step(WAI, 0, 8'h00, 0, 0, 32'h0);
        do_clr(WAI, 1'b0);
        step(RET, 0, 8'h00, 0, 0, 32'h0);
        check("clr_empties_stack", {24'd0, state}, 32'hFF);
        do_clr(INC, 1'b0);

        step(CAL, 0, 8'h30, 0, 0, 32'h0);
        step(CAL, 0, 8'h50, 0, 0, 32'h0);
        step(FET, 0, 8'h77, 0, 0, 32'h0);
        check("fetch_addr", {24'd0, state}, 32'h00);
        step(RET, 0, 8'h00, 0, 0, 32'h0);
        check("fetch_empties_stack", {31'd0, stack_err}, 32'd1);
        do_clr(INC, 1'b0);

        for (int n = 0; n < 800; n++) begin
            logic [2:0] mode;
            mode = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) mode = WAI;
            if ($urandom_range(0, 99) == 0) begin
                do_clr(mode, 1'($urandom_range(0, 1)));
            end else begin
                step(mode, 1'($urandom_range(0, 1)), 8'($urandom()), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0), $urandom());
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
# micro_sequencer

Parametrised microprogram sequencer for the CPU control path. It holds the current control-store address and selects the next one from the control-word fields: increment, jump, IR dispatch, conditional branch, wait-on-MOC with timeout, or call/return. The external control-store ROM is indexed by `state`, and its next-state fields feed back into this block. It generalises the fixed-encoding control unit with configurable address width, a configurable return stack and memory-timeout fault handling.

## Interface
Parameters:
- `ADDR_W`, 8, control-store address width
- `IR_W`, 32, instruction register width (must be ≥ 28)
- `STACK_DEPTH`, 4, return-stack entries (≥ 1)
- `MOC_TIMEOUT`, 15, max wait cycles for `moc`; 0 disables the timeout
- `FAULT_ADDR`, all-ones, microaddress entered on any fault

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock, rising edge
- `CLR`  in  1  synchronous active-high reset
- `moc`  in  1  memory-operation-complete
- `ir`  in  IR_W  instruction register
- `cond`  in  1  condition result from the flag/condition tester
- `ns_mode`  in  3  next-state mode from the control word
- `ns_inv`  in  1  inverts `cond` / `moc` sense
- `ns_target`  in  ADDR_W  jump, call or dispatch base address
- `state`  out  ADDR_W  current microaddress (registered)
- `waiting`  out  1  in WAIT mode and qualified `moc` is false (combinational)
- `mem_err`  out  1  sticky; MOC timeout occurred
- `stack_err`  out  1  sticky; push when full or pop when empty

## Operation
- Modes: 0 INC, 1 JUMP, 2 DISPATCH, 3 COND, 4 WAIT, 5 CALL, 6 RET, 7 FETCH.
- INC: next = state+1, mod 2^ADDR_W (wraps).
- JUMP: next = ns_target.
- DISPATCH: next = ns_target + zero-extended ir[27:24], mod 2^ADDR_W.
- COND: next = (cond^ns_inv) ? ns_target : state+1.
- WAIT: if (moc^ns_inv), next = state+1. Otherwise, if MOC_TIMEOUT≠0 and wait_cnt = MOC_TIMEOUT−1, next = FAULT_ADDR and mem_err←1. Otherwise next = state and wait_cnt increments.
- wait_cnt clears on every cycle whose mode is not WAIT, and on any transition out of the wait.
- CALL: push state+1, next = ns_target. If the stack is full: no push, next = FAULT_ADDR, stack_err←1.
- RET: pop, next = popped value. If the stack is empty: next = FAULT_ADDR, stack_err←1.
- FETCH: next = 0, and the stack pointer clears (abandons nested calls).
- Sticky errors clear only on CLR. Execution continues normally after entering FAULT_ADDR.

## Timing
- Reset values: state=0, sp=0, wait_cnt=0, mem_err=0, stack_err=0, waiting=0 (state 0 is never WAIT in a legal microprogram; `waiting` follows its equation regardless).
- One microstep per clock. The control-word fields and `moc` are sampled at the same edge that loads `state`. Latency from a field change to `state` is 1 cycle.
- WAIT with moc already high: the state advances at the first edge (zero stall). Maximum stall is MOC_TIMEOUT cycles; the fault address is loaded at edge MOC_TIMEOUT.
- The error flag asserts in the same cycle that `state` becomes FAULT_ADDR.
- CLR has priority over all modes, including mid-wait and mid-call: everything returns to reset values at that edge.
- Stack push/pop and the state update occur at the same edge. A CALL immediately followed by a RET returns to call-site+1.

## Structure
- Package `usq_pkg`: the mode encodings (INC..FETCH) as named constants, plus the dispatch field bounds (27:24).
- Sub-module `usq_stack`: a LIFO of STACK_DEPTH×ADDR_W with push/pop/clear and full/empty flags, sync reset.
- Top level contains the next-address mux, the state register, wait_cnt and the sticky flags.

## Test plan
- Reset then INC ×3 → state 0,1,2,3. INC at state 0xFF → 0x00.
- DISPATCH with ns_target=0x40 and ir=0x1AFFFFFD (ir[27:24]=0xA) → state 0x4A.
- COND with cond=1, ns_inv=0, target 0x20 → 0x20. The same with ns_inv=1 → state+1.
- WAIT with moc low for 3 cycles then high → state holds 3 cycles, then +1, waiting=1 during the hold. WAIT with moc low for 15 cycles → state=0xFF, mem_err=1, sticky until CLR.
- CALL ×4 (depth 4) from 0x10 then RET ×4 → returns in LIFO order. A 5th CALL → 0xFF with stack_err=1. RET on an empty stack → the same.
- CLR asserted mid-WAIT with sp=2 → next cycle state=0, sp=0, flags 0. FETCH → state 0, stack empty.
